// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: streams W_t and K_t for t=0..63 per block.
// Blocks run back-to-back; a 16-word sliding window feeds the expansion.
module sha256_msg_schedule #(
   parameter int DELAY_W = 7,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               running,
   input  logic               run,
   output logic               done,
   input  logic [DATA_W-1:0]  in0,
   output logic [DATA_W-1:0]  out0,
   output logic [DATA_W-1:0]  out1,
   input  logic [DELAY_W-1:0] delay0
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_STREAM = 2'd2
   } state_e;

   localparam logic [31:0] K_ROM [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   state_e             state_q, state_d;
   logic [DELAY_W-1:0] delay_q, delay_d;
   logic [5:0]         t_q, t_d;
   logic [31:0]        w_q [16];
   logic [31:0]        w_d [16];
   logic [31:0]        out0_q, out0_d;
   logic [31:0]        out1_q, out1_d;
   logic [31:0]        wn;
   logic               proc;

   assign done = (delay_q == '0);
   assign out0 = out0_q;
   assign out1 = out1_q;

   // Next word: message word for the first 16 rounds, expansion afterwards
   always_comb begin
      wn = in0;
      if (t_q[5:4] != 2'b00) begin
         wn = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
      end
   end

   // Next-state: run restarts, running gates all progress
   always_comb begin
      state_d = state_q;
      delay_d = delay_q;
      t_d     = t_q;
      w_d     = w_q;
      out0_d  = out0_q;
      out1_d  = out1_q;
      proc    = 1'b0;
      if (run) begin
         delay_d = delay0;
         t_d     = '0;
         state_d = S_WAIT;
      end else if (running) begin
         unique case (state_q)
            S_IDLE: ;
            S_WAIT: begin
               if (delay_q != '0) begin
                  delay_d = delay_q - 1'b1;
               end else begin
                  proc    = 1'b1;
                  state_d = S_STREAM;
               end
            end
            S_STREAM: proc = 1'b1;
            default: ;
         endcase
      end
      if (proc) begin
         out0_d = wn;
         out1_d = K_ROM[t_q];
         for (int i = 0; i < 15; i++) begin
            w_d[i] = w_q[i+1];
         end
         w_d[15] = wn;
         t_d     = t_q + 6'd1;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         delay_q <= '0;
         t_q     <= '0;
         out0_q  <= '0;
         out1_q  <= '0;
         for (int i = 0; i < 16; i++) begin
            w_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         delay_q <= delay_d;
         t_q     <= t_d;
         out0_q  <= out0_d;
         out1_q  <= out1_d;
         w_q     <= w_d;
      end
   end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: array-based reference model,
// per-cycle compare, plus literal checks from the FIPS "abc" vector.
module tb_sha256_msg_schedule;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        running = 1'b0;
   logic        run = 1'b0;
   logic        done;
   logic [31:0] in0 = '0;
   logic [31:0] out0;
   logic [31:0] out1;
   logic [6:0]  delay0 = '0;

   int ntest = 0;
   int nfail = 0;
   bit chk_en = 1'b0;

   sha256_msg_schedule dut (
      .clk(clk), .rst(rst), .running(running), .run(run),
      .done(done), .in0(in0), .out0(out0), .out1(out1),
      .delay0(delay0)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] KT [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(logic [31:0] x, int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ss0(logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ss1(logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Reference model: whole-block W array indexed by round number
   int          m_mode;
   int          m_delay;
   int          m_t;
   logic [31:0] m_w [64];
   logic [31:0] m_out0;
   logic [31:0] m_out1;

   always @(posedge clk or negedge rst) begin
      logic [31:0] word;
      if (!rst) begin
         m_mode  = 0;
         m_delay = 0;
         m_t     = 0;
         m_out0  = '0;
         m_out1  = '0;
      end else if (run) begin
         m_delay = int'(delay0);
         m_t     = 0;
         m_mode  = 1;
      end else if (running && m_mode != 0) begin
         if (m_mode == 1 && m_delay != 0) begin
            m_delay = m_delay - 1;
         end else begin
            if (m_t < 16) word = in0;
            else word = ss1(m_w[m_t-2]) + m_w[m_t-7]
                      + ss0(m_w[m_t-15]) + m_w[m_t-16];
            m_w[m_t] = word;
            m_out0   = word;
            m_out1   = KT[m_t];
            m_t      = (m_t + 1) % 64;
            m_mode   = 2;
         end
      end
   end

   // Per-cycle compare of DUT outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         ntest++;
         if (out0 !== m_out0 || out1 !== m_out1
             || done !== (m_delay == 0)) begin
            nfail++;
            $display("FAIL cycle @%0t: out0=%h out1=%h done=%b want %h %h %b",
                     $time, out0, out1, done, m_out0, m_out1, m_delay == 0);
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc(bit r, bit rn, logic [31:0] d, logic [6:0] dl);
      @(negedge clk);
      run     = r;
      running = rn;
      in0     = d;
      delay0  = dl;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] abc [16];
   logic [31:0] s0v, s1v;

   initial begin
      for (int i = 0; i < 16; i++) abc[i] = '0;
      abc[0]  = 32'h61626380;
      abc[15] = 32'h00000018;

      #1 rst = 1'b0;
      chk_en = 1'b1;
      repeat (3) cyc(0, 1, $urandom, 7'd0);
      chk("rst_done", {31'b0, done}, 32'd1);
      chk("rst_out0", out0, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // "abc" block
      cyc(1, 1, $urandom, 7'd0);
      for (int k = 0; k < 64; k++) begin
         cyc(0, 1, (k < 16) ? abc[k] : $urandom, 7'd0);
         if (k == 0) begin
            chk("abc_W0", out0, 32'h61626380);
            chk("abc_K0", out1, 32'h428A2F98);
         end
         if (k == 1) chk("abc_K1", out1, 32'h71374491);
         if (k == 15) chk("abc_W15", out0, 32'h00000018);
         if (k == 16) chk("abc_W16", out0, 32'h61626380);
         if (k == 17) chk("abc_W17", out0, 32'h000F0000);
         if (k == 63) chk("abc_K63", out1, 32'hC67178F2);
      end
      cyc(0, 1, 32'h0badf00d, 7'd0);
      chk("wrap_K0", out1, 32'h428A2F98);
      chk("wrap_M0", out0, 32'h0badf00d);

      // Reset mid-stream
      repeat (5) cyc(0, 1, $urandom, 7'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_out0", out0, 32'd0);
      chk("mid_rst_out1", out1, 32'd0);
      chk("mid_rst_done", {31'b0, done}, 32'd1);
      repeat (2) cyc(0, 1, $urandom, 7'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) cyc(0, 1, $urandom, 7'd3);
      chk("idle_out0", out0, 32'd0);

      // Start delay of 5
      cyc(1, 1, $urandom, 7'd5);
      for (int i = 0; i < 5; i++) begin
         chk("dly_done0", {31'b0, done}, 32'd0);
         cyc(0, 1, 32'hdead0000 | i, 7'd0);
      end
      chk("dly_done1", {31'b0, done}, 32'd1);
      chk("dly_hold", out0, 32'd0);
      cyc(0, 1, 32'h12345678, 7'd0);
      chk("dly_first", out0, 32'h12345678);

      // Stall at t=20
      cyc(1, 1, $urandom, 7'd0);
      repeat (20) cyc(0, 1, $urandom, 7'd0);
      s0v = out0;
      s1v = out1;
      repeat (3) cyc(0, 0, $urandom, 7'd0);
      chk("stall_out0", out0, s0v);
      chk("stall_out1", out1, s1v);
      cyc(0, 1, $urandom, 7'd0);
      chk("stall_K20", out1, 32'h2de92c6f);
      repeat (30) cyc(0, 1, $urandom, 7'd0);

      // Back-to-back blocks
      cyc(1, 1, $urandom, 7'd0);
      repeat (128) cyc(0, 1, $urandom, 7'd0);

      // Random run/running/delay mix
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0,
             $urandom, 7'($urandom_range(0, 3)));
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
